// File: rtl/crc_frame_chk.sv
// Frame-level CRC checker: sof/eof framed beats of DW bits, configurable CRC,
// one-cycle verdict after eof, held frame length/CRC, saturating statistics.
module crc_frame_chk #(
   parameter int                 DW      = 8,
   parameter int                 CRC_W   = 16,
   parameter logic [CRC_W-1:0]   POLY    = 16'h8005,
   parameter logic [CRC_W-1:0]   INIT    = 16'hFFFF,
   parameter bit                 REFIN   = 1'b1,
   parameter logic [CRC_W-1:0]   RESIDUE = 16'h0000,
   parameter int                 MAX_LEN = 128,
   parameter int                 CNT_W   = 8,
   localparam int                LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             sclk,
   input  logic             reset,
   input  logic             init,
   input  logic             clr_cnt,
   input  logic             s_valid,
   input  logic [DW-1:0]    s_data,
   input  logic             s_sof,
   input  logic             s_eof,
   output logic             done,
   output logic             crc_ok,
   output logic             crc_err,
   output logic             len_err,
   output logic             proto_err,
   output logic [LEN_W-1:0] frame_len,
   output logic [CRC_W-1:0] crc_value,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int BPB     = DW / 8;
   localparam int MIN_LEN = CRC_W / 8 + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic [CRC_W-1:0]   crc_q, crc_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;
   logic               ok_q, ok_d;
   logic               err_q, err_d;
   logic               lerr_q, lerr_d;
   logic               proto_q, proto_d;
   logic [LEN_W-1:0]   frame_len_q, frame_len_d;
   logic [CRC_W-1:0]   crc_value_q, crc_value_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

   // Whole beat folded in one cycle, lane 0 first; REFIN feeds each byte LSB first.
   function automatic logic [CRC_W-1:0] crc_upd(input logic [CRC_W-1:0] c,
                                                input logic [DW-1:0]    d);
      logic [CRC_W-1:0] r;
      logic             b;
      logic             fb;
      r = c;
      for (int i = 0; i < BPB; i++) begin
         for (int j = 0; j < 8; j++) begin
            b  = REFIN ? d[8*i+j] : d[8*i+7-j];
            fb = r[CRC_W-1] ^ b;
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
         end
      end
      return r;
   endfunction

   logic               start_new;
   logic [CRC_W-1:0]   crc_nxt;
   logic [LEN_W:0]     len_sum;
   logic [LEN_W-1:0]   len_nxt;
   logic               ovf_nxt;
   logic               ovf_base;

   // A sof beat (or any accepted beat from IDLE) restarts from INIT.
   always_comb begin
      start_new = s_sof || (state_q == IDLE);
      crc_nxt   = crc_upd(start_new ? INIT : crc_q, s_data);
      ovf_base  = start_new ? 1'b0 : ovf_q;
      len_sum   = (start_new ? '0 : {1'b0, len_q}) + (LEN_W+1)'(BPB);
      if (ovf_base || (len_sum > (LEN_W+1)'(MAX_LEN))) begin
         ovf_nxt = 1'b1;
         len_nxt = LEN_W'(MAX_LEN + 1);
      end else begin
         ovf_nxt = 1'b0;
         len_nxt = len_sum[LEN_W-1:0];
      end
   end

   logic inc_frame;
   logic inc_err;

   always_comb begin
      state_d     = state_q;
      crc_d       = crc_q;
      len_d       = len_q;
      ovf_d       = ovf_q;
      done_d      = 1'b0;
      ok_d        = 1'b0;
      err_d       = 1'b0;
      lerr_d      = 1'b0;
      proto_d     = 1'b0;
      frame_len_d = frame_len_q;
      crc_value_d = crc_value_q;
      inc_frame   = 1'b0;
      inc_err     = 1'b0;

      if (init) begin
         state_d = IDLE;
         crc_d   = INIT;
         len_d   = '0;
         ovf_d   = 1'b0;
      end else if (s_valid) begin
         if ((state_q == IDLE) && !s_sof) begin
            proto_d = 1'b1;
         end else begin
            proto_d = (state_q == RUN) && s_sof;
            if (s_eof) begin
               state_d     = IDLE;
               crc_d       = INIT;
               len_d       = '0;
               ovf_d       = 1'b0;
               done_d      = 1'b1;
               frame_len_d = len_nxt;
               crc_value_d = crc_nxt;
               inc_frame   = 1'b1;
               if (ovf_nxt || (len_nxt < LEN_W'(MIN_LEN))) begin
                  lerr_d  = 1'b1;
                  inc_err = 1'b1;
               end else if (crc_nxt == RESIDUE) begin
                  ok_d    = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  inc_err = 1'b1;
               end
            end else begin
               state_d = RUN;
               crc_d   = crc_nxt;
               len_d   = len_nxt;
               ovf_d   = ovf_nxt;
            end
         end
      end

      // Clear wins over a same-cycle increment.
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (clr_cnt) begin
         frame_cnt_d = '0;
         err_cnt_d   = '0;
      end else begin
         if (inc_frame && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 1'b1;
         if (inc_err && (err_cnt_q != '1))     err_cnt_d   = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sclk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         crc_q       <= INIT;
         len_q       <= '0;
         ovf_q       <= 1'b0;
         done_q      <= 1'b0;
         ok_q        <= 1'b0;
         err_q       <= 1'b0;
         lerr_q      <= 1'b0;
         proto_q     <= 1'b0;
         frame_len_q <= '0;
         crc_value_q <= '0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         crc_q       <= crc_d;
         len_q       <= len_d;
         ovf_q       <= ovf_d;
         done_q      <= done_d;
         ok_q        <= ok_d;
         err_q       <= err_d;
         lerr_q      <= lerr_d;
         proto_q     <= proto_d;
         frame_len_q <= frame_len_d;
         crc_value_q <= crc_value_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign done      = done_q;
   assign crc_ok    = ok_q;
   assign crc_err   = err_q;
   assign len_err   = lerr_q;
   assign proto_err = proto_q;
   assign frame_len = frame_len_q;
   assign crc_value = crc_value_q;
   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_crc_frame_chk.sv
// Scoreboard bench for crc_frame_chk: DW=8 and DW=32 instances, directed frames,
// expected verdicts queued at eof and compared by per-instance monitors.
module tb_crc_frame_chk;

   logic sclk  = 1'b0;
   logic reset = 1'b0;
   always #5 sclk = ~sclk;

   int cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   // DW=8 instance
   logic        init8 = 0, clr8 = 0, v8 = 0, sof8 = 0, eof8 = 0;
   logic [7:0]  d8 = 0;
   logic        done8, ok8, err8, lerr8, perr8;
   logic [7:0]  flen8, fcnt8, ecnt8;
   logic [15:0] cval8;

   crc_frame_chk u8 (
      .sclk(sclk), .reset(reset), .init(init8), .clr_cnt(clr8),
      .s_valid(v8), .s_data(d8), .s_sof(sof8), .s_eof(eof8),
      .done(done8), .crc_ok(ok8), .crc_err(err8), .len_err(lerr8),
      .proto_err(perr8), .frame_len(flen8), .crc_value(cval8),
      .frame_cnt(fcnt8), .err_cnt(ecnt8));

   // DW=32 instance
   logic        init32 = 0, clr32 = 0, v32 = 0, sof32 = 0, eof32 = 0;
   logic [31:0] d32 = 0;
   logic        done32, ok32, err32, lerr32, perr32;
   logic [7:0]  flen32, fcnt32, ecnt32;
   logic [15:0] cval32;

   crc_frame_chk #(.DW(32)) u32 (
      .sclk(sclk), .reset(reset), .init(init32), .clr_cnt(clr32),
      .s_valid(v32), .s_data(d32), .s_sof(sof32), .s_eof(eof32),
      .done(done32), .crc_ok(ok32), .crc_err(err32), .len_err(lerr32),
      .proto_err(perr32), .frame_len(flen32), .crc_value(cval32),
      .frame_cnt(fcnt32), .err_cnt(ecnt32));

   typedef struct {
      int          cyc;
      logic        ok, err, lerr;
      int          len;
      logic        chkv;
      logic [15:0] val;
      int          fc, ec;
   } exp_t;

   exp_t q8[$];
   exp_t q32[$];
   exp_t e8, e32;
   int   npass = 0, ntot = 0;
   int   m_f8 = 0, m_e8 = 0, m_f32 = 0, m_e32 = 0;
   int   perr_n8 = 0, perr_n32 = 0;

   logic [7:0]  buf8  [0:199];
   logic [31:0] buf32 [0:7];

   task automatic chk(input string nm, input longint act, input longint exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic cmp(input string tag, input exp_t e, input logic ok, err, lerr,
                      input int len, input logic [15:0] val, input int fc, ec);
      chk({tag, ".latency"},   cyc,  e.cyc);
      chk({tag, ".crc_ok"},    ok,   e.ok);
      chk({tag, ".crc_err"},   err,  e.err);
      chk({tag, ".len_err"},   lerr, e.lerr);
      chk({tag, ".frame_len"}, len,  e.len);
      if (e.chkv) chk({tag, ".crc_value"}, val, e.val);
      chk({tag, ".frame_cnt"}, fc,   e.fc);
      chk({tag, ".err_cnt"},   ec,   e.ec);
   endtask

   always @(negedge sclk) if (reset) begin
      if (perr8) perr_n8++;
      if (done8) begin
         if (q8.size() == 0) chk("u8.spurious_done", 1, 0);
         else begin
            e8 = q8.pop_front();
            cmp("u8", e8, ok8, err8, lerr8, int'(flen8), cval8, int'(fcnt8), int'(ecnt8));
         end
      end
   end

   always @(negedge sclk) if (reset) begin
      if (perr32) perr_n32++;
      if (done32) begin
         if (q32.size() == 0) chk("u32.spurious_done", 1, 0);
         else begin
            e32 = q32.pop_front();
            cmp("u32", e32, ok32, err32, lerr32, int'(flen32), cval32, int'(fcnt32), int'(ecnt32));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge sclk);
      #1;
   endtask

   task automatic beat8(input logic [7:0] d, input logic sof, input logic eof);
      v8 = 1; d8 = d; sof8 = sof; eof8 = eof;
      @(posedge sclk); #1;
      v8 = 0; sof8 = 0; eof8 = 0;
   endtask

   task automatic beat32(input logic [31:0] d, input logic sof, input logic eof);
      v32 = 1; d32 = d; sof32 = sof; eof32 = eof;
      @(posedge sclk); #1;
      v32 = 0; sof32 = 0; eof32 = 0;
   endtask

   task automatic expect8(input logic ok, err, lerr, input int len,
                          input logic chkv, input logic [15:0] val, input logic clr);
      exp_t e;
      if (clr) begin m_f8 = 0; m_e8 = 0; end
      else begin
         if (m_f8 < 255) m_f8++;
         if (!ok && m_e8 < 255) m_e8++;
      end
      e.cyc = cyc; e.ok = ok; e.err = err; e.lerr = lerr; e.len = len;
      e.chkv = chkv; e.val = val; e.fc = m_f8; e.ec = m_e8;
      q8.push_back(e);
   endtask

   task automatic expect32(input logic ok, err, lerr, input int len,
                           input logic chkv, input logic [15:0] val);
      exp_t e;
      if (m_f32 < 255) m_f32++;
      if (!ok && m_e32 < 255) m_e32++;
      e.cyc = cyc; e.ok = ok; e.err = err; e.lerr = lerr; e.len = len;
      e.chkv = chkv; e.val = val; e.fc = m_f32; e.ec = m_e32;
      q32.push_back(e);
   endtask

   task automatic frame8(input int n, input logic ok, err, lerr, input int len,
                         input logic chkv, input logic [15:0] val);
      logic c;
      c = 1'b0;
      for (int i = 0; i < n; i++) begin
         c = clr8;
         beat8(buf8[i], i == 0, i == n - 1);
      end
      expect8(ok, err, lerr, len, chkv, val, c);
   endtask

   task automatic frame32(input int n, input logic ok, err, lerr, input int len,
                          input logic chkv, input logic [15:0] val);
      for (int i = 0; i < n; i++) beat32(buf32[i], i == 0, i == n - 1);
      expect32(ok, err, lerr, len, chkv, val);
   endtask

   task automatic load_good;
      for (int i = 0; i < 9; i++) buf8[i] = 8'h31 + 8'(i);
      buf8[9]  = 8'h37;
      buf8[10] = 8'h4B;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge sclk);
      @(negedge sclk);
      chk("rst.done",      done8, 0);
      chk("rst.crc_ok",    ok8,   0);
      chk("rst.crc_err",   err8,  0);
      chk("rst.len_err",   lerr8, 0);
      chk("rst.proto_err", perr8, 0);
      chk("rst.frame_len", flen8, 0);
      chk("rst.crc_value", cval8, 0);
      chk("rst.frame_cnt", fcnt8, 0);
      chk("rst.err_cnt",   ecnt8, 0);
      @(posedge sclk); #1;
      reset = 1;
      idle(2);

      // Modbus "123456789" + 37 4B: residue 0
      load_good;
      frame8(11, 1, 0, 0, 11, 1, 16'h0000);
      // last byte flipped in bit 0: register differs by one injected bit + 7 shifts
      buf8[10] = 8'h4A;
      frame8(11, 0, 1, 0, 11, 1, 16'h8303);
      buf8[0] = 8'h55;
      frame8(1, 0, 0, 1, 1, 0, 16'h0000);
      for (int i = 0; i < 129; i++) buf8[i] = 8'h00;
      frame8(129, 0, 0, 1, 129, 0, 16'h0000);
      idle(2);
      chk("u8.proto_none", perr_n8, 0);

      // stray beat in IDLE, then sof mid-frame restarting a good frame
      beat8(8'h00, 0, 0);
      load_good;
      for (int i = 0; i < 4; i++) beat8(buf8[i], i == 0, 0);
      frame8(11, 1, 0, 0, 11, 1, 16'h0000);
      idle(2);
      chk("u8.proto_two", perr_n8, 2);
      chk("u8.sb_empty1", q8.size(), 0);

      // async reset mid-frame: everything clears, no verdict
      for (int i = 0; i < 3; i++) beat8(buf8[i], i == 0, 0);
      reset = 0;
      #2;
      chk("midrst.frame_cnt", fcnt8, 0);
      chk("midrst.err_cnt",   ecnt8, 0);
      chk("midrst.frame_len", flen8, 0);
      chk("midrst.crc_value", cval8, 0);
      m_f8 = 0; m_e8 = 0;
      @(posedge sclk); #1;
      reset = 1;
      idle(3);
      frame8(11, 1, 0, 0, 11, 1, 16'h0000);

      // init aborts the frame: trailing eof beat lands in IDLE
      beat8(8'h31, 1, 0);
      beat8(8'h32, 0, 0);
      init8 = 1;
      beat8(8'h33, 0, 0);
      init8 = 0;
      beat8(8'h34, 0, 1);
      idle(2);
      chk("u8.proto_init", perr_n8, 3);
      frame8(11, 1, 0, 0, 11, 1, 16'h0000);

      // clr_cnt wins over the increment of a verdict in the same cycle
      buf8[0] = 8'h55;
      clr8 = 1;
      frame8(1, 0, 0, 1, 1, 0, 16'h0000);
      clr8 = 0;
      idle(1);
      chk("clr_prio.frame_cnt", fcnt8, 0);

      // saturation
      for (int k = 0; k < 257; k++) frame8(1, 0, 0, 1, 1, 0, 16'h0000);
      idle(2);
      chk("sat.err_cnt",   ecnt8, 255);
      chk("sat.frame_cnt", fcnt8, 255);
      clr8 = 1;
      idle(1);
      clr8 = 0;
      chk("clr.err_cnt",   ecnt8, 0);
      chk("clr.frame_cnt", fcnt8, 0);
      m_f8 = 0; m_e8 = 0;

      // DW=32: 31..39 37 4B 00 lane-0-first; trailing zero byte keeps residue 0
      buf32[0] = 32'h34333231;
      buf32[1] = 32'h38373635;
      buf32[2] = 32'h004B3739;
      frame32(3, 1, 0, 0, 12, 1, 16'h0000);
      // CRC bytes swapped within the last beat
      buf32[2] = 32'h00374B39;
      frame32(3, 0, 1, 0, 12, 0, 16'h0000);
      // byte order reversed inside every beat
      buf32[0] = 32'h31323334;
      buf32[1] = 32'h35363738;
      buf32[2] = 32'h394B3700;
      frame32(3, 0, 1, 0, 12, 0, 16'h0000);
      // back-to-back with the good frame again
      buf32[0] = 32'h34333231;
      buf32[1] = 32'h38373635;
      buf32[2] = 32'h004B3739;
      frame32(3, 1, 0, 0, 12, 1, 16'h0000);
      idle(3);
      chk("u32.proto_none", perr_n32, 0);

      chk("u8.sb_empty",  q8.size(),  0);
      chk("u32.sb_empty", q32.size(), 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
